shift_seq_unit: RTL

// - Parametrised sequential shifter for the 16-bit datapath; next generation of the fixed byte-shift unit.
// - Shifts a WIDTH-bit operand by a run-time amount in one of four modes.
// - Each cycle moves the operand by STEP bits (byte stride) or by 1 bit.
// - Valid/ready on both sides; sits between the ALU operand mux and the writeback mux.

---
 rtl/shift_seq_unit_pkg.sv | 18 +
 rtl/shift_seq_unit_step.sv | 32 +++
 rtl/shift_seq_unit.sv | 96 +++++++++
 3 files changed

// File: rtl/shift_seq_unit_pkg.sv
// Shared encodings for the sequential shifter.
// Mode and FSM state types used by the top and the step datapath.
package shift_seq_unit_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROL = 2'b11
  } sh_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } sh_state_e;

endpackage

// File: rtl/shift_seq_unit_step.sv
// One shift step of the sequential shifter.
// Moves the value by STEP bits or by a single bit.
import shift_seq_unit_pkg::*;

module shift_step #(
  parameter int WIDTH = 16,
  parameter int STEP  = 8
) (
  input  logic [WIDTH-1:0] value,
  input  sh_mode_e         mode,
  input  logic             sel_coarse,
  input  logic             msb_fill,
  output logic [WIDTH-1:0] result
);

  int               k;
  logic [WIDTH-1:0] fill;

  always_comb begin
    k      = sel_coarse ? STEP : 1;
    fill   = {WIDTH{msb_fill}} << (WIDTH - k);
    result = value;
    unique case (mode)
      SH_SLL: result = value << k;
      SH_SRL: result = value >> k;
      SH_SRA: result = fill | (value >> k);
      SH_ROL: result = (value << k) | (value >> (WIDTH - k));
      default: result = value;
    endcase
  end

endmodule

// File: rtl/shift_seq_unit.sv
// Sequential shifter: FSM, remaining-amount counter, operand/result regs.
// Accepts one request at a time and shifts it in coarse or single-bit steps.
import shift_seq_unit_pkg::*;

module shift_seq_unit #(
  parameter  int WIDTH = 16,
  parameter  int STEP  = 8,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);
  localparam logic [AMT_W-1:0] ONE_A  = AMT_W'(1);

  sh_state_e        state, state_nx;
  sh_mode_e         mode_q;
  logic             msb_q;
  logic [WIDTH-1:0] data_q, out_q, step_val;
  logic [AMT_W-1:0] rem_q, rem_nx;
  logic             sel_coarse;
  logic             accept;

  assign in_ready   = (state == ST_IDLE);
  assign out_valid  = (state == ST_DONE);
  assign out_data   = out_q;
  assign accept     = in_valid && in_ready && !flush;
  assign sel_coarse = (rem_q >= STEP_A);
  assign rem_nx     = rem_q - (sel_coarse ? STEP_A : ONE_A);

  shift_step #(
    .WIDTH(WIDTH),
    .STEP (STEP)
  ) u_step (
    .value     (data_q),
    .mode      (mode_q),
    .sel_coarse(sel_coarse),
    .msb_fill  (msb_q),
    .result    (step_val)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:
          if (in_valid)
            state_nx = (in_amt == '0) ? ST_DONE : ST_SHIFT;
        ST_SHIFT:
          if (rem_nx == '0) state_nx = ST_DONE;
        ST_DONE:
          if (out_ready) state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Result register only loads on entry to DONE; flush leaves it untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      out_q  <= '0;
      rem_q  <= '0;
      mode_q <= SH_SLL;
      msb_q  <= 1'b0;
    end else if (accept) begin
      data_q <= in_data;
      mode_q <= sh_mode_e'(in_mode);
      msb_q  <= in_data[WIDTH-1];
      rem_q  <= in_amt;
      if (in_amt == '0) out_q <= in_data;
    end else if (!flush && state == ST_SHIFT) begin
      data_q <= step_val;
      rem_q  <= rem_nx;
      if (rem_nx == '0) out_q <= step_val;
    end
  end

endmodule
